multdiv_arbiter: RTL and testbench
==================================

MULTDIV_ARBITER -- requirements
Module: multdiv_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 40, SHALL be the maximum number of WAIT cycles allowed before an operation is abandoned.
REQ-002 clock  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  in  2  SHALL carry the per-requester request strobe; bit i belongs to requester i.
REQ-005 req_op  in  2  SHALL carry the per-requester opcode: 0 = multiply, 1 = divide.
REQ-006 req_a, req_b  in  64 each  SHALL carry the operands; requester i uses bits [32i+31:32i].
REQ-007 req_ready  out  2  SHALL signal per-requester request acceptance; a transfer occurs on req_valid[i] & req_ready[i].
REQ-008 md_operandA, md_operandB  out  32 each  SHALL drive the operands to the multdiv unit.
REQ-009 md_ctrl_MULT, md_ctrl_DIV  out  1 each  SHALL be the multdiv start strobes.
REQ-010 md_result  in  32, md_exception  in  1, md_resultRDY  in  1  SHALL be the multdiv outputs.
REQ-011 rsp_valid  out  2  SHALL signal, per requester, that a response is pending for that requester.
REQ-012 rsp_ready  in  2  SHALL signal, per requester, that the response is accepted.
REQ-013 rsp_result  out  32, rsp_exception  out  1, rsp_timeout  out  1  SHALL carry the response payload, which is shared by both requesters.

Function
REQ-014 The block SHALL use four states, IDLE, ISSUE, WAIT and RESP, with at most one operation in flight.
REQ-015 IDLE SHALL assert req_ready combinationally for exactly one requester with req_valid set, chosen round-robin.
REQ-016 Arbitration SHALL grant the sole valid requester; if both are valid, it SHALL grant the one not granted last; after reset the last-grant pointer SHALL be 1, so requester 0 wins first.
REQ-017 On a transfer, the block SHALL register the operands, op and grant index, then go to ISSUE; req_ready SHALL be 0 in all other states.
REQ-018 ISSUE SHALL last exactly one cycle and assert md_ctrl_MULT (op 0) or md_ctrl_DIV (op 1), never both; it then goes to WAIT with the counter cleared.
REQ-019 md_operandA/B SHALL equal the registered operands from ISSUE through the end of WAIT, and SHALL be 0 in IDLE after reset.
REQ-020 md_resultRDY SHALL be ignored in IDLE, ISSUE and RESP, because a stale ready from a prior operation is possible.
REQ-021 In WAIT, md_resultRDY=1 SHALL capture md_result and md_exception, set timeout=0, and go to RESP.
REQ-022 In WAIT, the counter SHALL increment each cycle; if it reaches TIMEOUT-1 without md_resultRDY, the block SHALL go to RESP with result 0, exception 1 and timeout 1.
REQ-023 If md_resultRDY coincides with the timeout cycle, the result SHALL win.
REQ-024 RESP SHALL hold rsp_valid[grant]=1 with a stable payload until rsp_ready[grant]=1, then return to IDLE; rsp_ready on the other bit SHALL be ignored.
REQ-025 Latency SHALL be: transfer in cycle T, strobe in T+1, md_resultRDY sampled in cycle R≥T+2, rsp_valid from R+1.
REQ-026 The block SHALL NOT accept a new request in the cycle the response handshake completes (no IDLE bypass).
REQ-027 rsp_* SHALL be 0 outside RESP.
REQ-028 A divide-by-zero exception SHALL be passed through unmodified from md_exception.

Reset
REQ-029 On reset the block SHALL enter IDLE, and all outputs SHALL be 0.
REQ-030 On reset the counter SHALL be 0, the last-grant pointer SHALL be 1, and the registered operands SHALL be 0.
REQ-031 Reset mid-operation SHALL abandon the operation without a response; the next ISSUE strobe restarts multdiv.

Structure
REQ-032 Package multdiv_arb_pkg SHALL hold the state enum, the op encoding (OP_MULT=0, OP_DIV=1) and the default TIMEOUT.
REQ-033 The two-way round-robin grant logic SHALL be a sub-module named rr_arbiter2, with pointer update on the transfer only.

Verification
REQ-034 Req0 mul 7×6 alone -> req_ready[0] in T, md_ctrl_MULT one cycle in T+1, rsp_valid[0] with result 42, exception 0 one cycle after md_resultRDY.
REQ-035 Both valid in the same cycle after reset (req0 div 100/7, req1 mul 3×5) -> req0 served first with result 14, then req1 with result 15; a repeat of both -> req1 granted before req0.
REQ-036 Div 5/0 -> rsp_exception=1 and rsp_timeout=0, passed through from the multdiv model.
REQ-037 Model never raises md_resultRDY, TIMEOUT=40 -> rsp_valid after 40 WAIT cycles with result 0, exception 1, timeout 1.
REQ-038 rsp_ready held low for 10 cycles -> payload stable, req_ready stays 0, and a new request is accepted only the cycle after the handshake.
REQ-039 Reset asserted in WAIT, with md_resultRDY arriving afterwards -> no rsp_valid, all outputs 0, and the next request completes normally.

Source files
------------

// File: rtl/multdiv_arb_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_arb_pkg
// Shared types and constants for the two-requester multdiv arbiter:
//   state_t          - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   op_t             - request opcode encoding (OP_MULT = 0, OP_DIV = 1)
//   DEFAULT_TIMEOUT  - default number of WAIT cycles before an operation
//                      is abandoned
// ---------------------------------------------------------------------------
package multdiv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A sole requester is granted outright; when
// both request, the one not granted last wins. The last-grant pointer only
// moves when the grant is actually consumed (advance = 1).
//   clock, reset  - clock and synchronous active-high reset
//   req           - request vector, bit i = requester i
//   advance       - grant consumed this cycle; update the pointer
//   grant         - one-hot grant (all zero when nothing requests)
//   grant_idx     - index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned and a latch is inferred.
        grant_idx = 1'b0;
        grant     = 2'b00;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_q;
            default: grant_idx = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = 2'b01 << grant_idx;
        end
    end

    // Pointer comes out of reset at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values present before the clock edge.
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/multdiv_arbiter.sv
// ---------------------------------------------------------------------------
// multdiv_arbiter
// Shares one multiply/divide unit between two requesters, one operation in
// flight at a time. Sequence: IDLE (round-robin accept) -> ISSUE (one-cycle
// start strobe) -> WAIT (result or timeout) -> RESP (hold until accepted).
//   clock, reset                - clock, synchronous active-high reset
//   req_valid/req_ready [1:0]   - per-requester request handshake
//   req_op [1:0]                - per-requester opcode (0 mul, 1 div)
//   req_a, req_b [63:0]         - operands, requester i in bits [32i+31:32i]
//   md_operandA/B, md_ctrl_*    - operands and start strobes to multdiv
//   md_result/exception/RDY     - multdiv result inputs
//   rsp_valid/rsp_ready [1:0]   - per-requester response handshake
//   rsp_result/exception/timeout- shared response payload
// ---------------------------------------------------------------------------
module multdiv_arbiter
    import multdiv_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  req_ready,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_exception,
    output logic        rsp_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [31:0]       a_q, b_q, res_q;
    op_t               op_q;
    logic              gidx_q, exc_q, tmo_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        arb_grant;
    logic              arb_idx;
    logic              xfer, cap_result, cap_timeout;

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .advance   (xfer),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 2'b00;
        md_ctrl_MULT  = 1'b0;
        md_ctrl_DIV   = 1'b0;
        md_operandA   = '0;
        md_operandB   = '0;
        rsp_valid     = 2'b00;
        rsp_result    = '0;
        rsp_exception = 1'b0;
        rsp_timeout   = 1'b0;
        xfer          = 1'b0;
        cap_result    = 1'b0;
        cap_timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = arb_grant;
                if ((req_valid & arb_grant) != 2'b00) begin
                    xfer    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                md_ctrl_MULT = (op_q == OP_MULT);
                md_ctrl_DIV  = (op_q == OP_DIV);
                md_operandA  = a_q;
                md_operandB  = b_q;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                md_operandA = a_q;
                md_operandB = b_q;
                // A result arriving on the last allowed cycle beats the timeout.
                if (md_resultRDY) begin
                    cap_result = 1'b1;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap_timeout = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                rsp_result        = res_q;
                rsp_exception     = exc_q;
                rsp_timeout       = tmo_q;
                // Returning to IDLE (not accepting here) keeps one idle cycle
                // between a response handshake and the next request.
                if (rsp_ready[gidx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: the operand/result registers are cleared on reset along with
        // the control state, so nothing from an abandoned operation survives.
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_MULT;
            gidx_q <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            exc_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (xfer) begin
                a_q    <= req_a[{arb_idx, 5'd0} +: 32];
                b_q    <= req_b[{arb_idx, 5'd0} +: 32];
                op_q   <= op_t'(req_op[arb_idx]);
                gidx_q <= arb_idx;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cap_result) begin
                res_q <= md_result;
                exc_q <= md_exception;
                tmo_q <= 1'b0;
            end else if (cap_timeout) begin
                res_q <= '0;
                exc_q <= 1'b1;
                tmo_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multdiv_arbiter
// Scoreboard bench: the expected response is pushed when a request is
// accepted and popped when the response handshake is taken. A small
// behavioural multdiv model answers start strobes after md_lat cycles.
// ---------------------------------------------------------------------------
module tb_multdiv_arbiter;
    import multdiv_arb_pkg::*;

    localparam int TMO    = 40;
    localparam int BUDGET = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [1:0]  req_ready;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_exception, rsp_timeout;

    always #5 clock = ~clock;

    multdiv_arbiter #(.TIMEOUT(TMO)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .md_operandA   (md_operandA),
        .md_operandB   (md_operandB),
        .md_ctrl_MULT  (md_ctrl_MULT),
        .md_ctrl_DIV   (md_ctrl_DIV),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .md_resultRDY  (md_resultRDY),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .rsp_timeout   (rsp_timeout)
    );

    typedef struct {
        logic        idx;
        logic [31:0] res;
        logic        exc;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the multdiv unit.
    function automatic void md_fn(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        if (op == OP_DIV) begin
            if (b == 32'd0) begin
                r = 32'hFFFF_FFFF;
                e = 1'b1;
            end else begin
                r = a / b;
                e = 1'b0;
            end
        end else begin
            r = a * b;
            e = 1'b0;
        end
    endfunction

    // Multdiv model: noise on result lines except in the ready cycle.
    int          md_lat   = 2;
    bit          md_never = 1'b0;
    logic        md_busy  = 1'b0;
    int          md_cnt   = 0;
    logic [31:0] md_pres  = '0;
    logic        md_pexc  = 1'b0;

    always @(posedge clock) begin : md_model
        logic [31:0] r;
        logic        e;
        md_resultRDY <= 1'b0;
        md_result    <= $urandom();
        md_exception <= 1'($urandom_range(0, 1));
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            md_fn(md_ctrl_DIV, md_operandA, md_operandB, r, e);
            md_pres <= r;
            md_pexc <= e;
            md_busy <= 1'b1;
            md_cnt  <= md_lat;
        end else if (md_busy && !md_never) begin
            if (md_cnt == 0) begin
                md_resultRDY <= 1'b1;
                md_result    <= md_pres;
                md_exception <= md_pexc;
                md_busy      <= 1'b0;
            end else begin
                md_cnt <= md_cnt - 1;
            end
        end
    end

    // Strobe monitor: one cycle long, never both.
    int   cyc = 0;
    int   strobe_cyc = -1000;
    logic prev_strobe = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            strobe_cyc = cyc;
            check("strobe_excl", 32'(md_ctrl_MULT & md_ctrl_DIV), 32'd0);
            check("strobe_1cyc", 32'(prev_strobe), 32'd0);
        end
        prev_strobe = md_ctrl_MULT | md_ctrl_DIV;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic op, input logic [31:0] a, input logic [31:0] b);
        req_valid[idx]       = 1'b1;
        req_op[idx]          = op;
        req_a[32*idx +: 32]  = a;
        req_b[32*idx +: 32]  = b;
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_opA"}, md_operandA, 32'd0);
        check({tag, "_opB"}, md_operandB, 32'd0);
        check({tag, "_strobes"}, 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_payload"}, rsp_result | 32'({rsp_exception, rsp_timeout}), 32'd0);
    endtask

    // Wait for requester idx to be granted, record its expected response,
    // then verify the ISSUE cycle.
    task automatic wait_grant(input int idx);
        int          n = 0;
        exp_t        e;
        logic        op;
        logic [31:0] a, b;
        while (req_ready == 2'b00 && n < BUDGET) begin
            tick();
            n++;
        end
        check("grant", 32'(req_ready), 32'd1 << idx);
        if (req_ready == 2'b00) return;
        op = req_op[idx];
        a  = req_a[32*idx +: 32];
        b  = req_b[32*idx +: 32];
        e.idx = 1'(idx);
        if (md_never) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.tmo = 1'b1;
        end else begin
            md_fn(op, a, b, e.res, e.exc);
            e.tmo = 1'b0;
        end
        exp_q.push_back(e);
        tick();
        req_valid[idx] = 1'b0;
        check("issue_mult", 32'(md_ctrl_MULT), 32'(!op));
        check("issue_div", 32'(md_ctrl_DIV), 32'(op));
        check("issue_opA", md_operandA, a);
        check("issue_opB", md_operandB, b);
        check("issue_req_ready", 32'(req_ready), 32'd0);
    endtask

    // Wait for the response to requester idx, hold rsp_ready low for 'hold'
    // cycles (with the other bit raised, which must be ignored), then accept.
    task automatic take_rsp(input int idx, input int hold);
        int          n = 0;
        logic        prev_rdy = 1'b0;
        exp_t        e;
        logic [31:0] want;
        want = 32'd1 << idx;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        while (rsp_valid == 2'b00 && n < BUDGET) begin
            prev_rdy = md_resultRDY;
            tick();
            n++;
        end
        check("rsp_valid", 32'(rsp_valid), want);
        if (rsp_valid == 2'b00) return;
        if (e.tmo) check("tmo_latency", cyc - strobe_cyc, TMO + 1);
        else       check("rsp_latency", 32'(prev_rdy), 32'd1);
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid_hold", 32'(rsp_valid), want);
            check("rsp_result", rsp_result, e.res);
            check("rsp_exception", 32'(rsp_exception), 32'(e.exc));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            if (h < hold) begin
                rsp_ready = 2'(want ^ 32'd3);
                tick();
            end else begin
                rsp_ready = 2'(want);
                #1;
                check("resp_req_ready", 32'(req_ready), 32'd0);
            end
        end
        tick();
        rsp_ready = 2'b00;
        #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();

        // Lone multiply 7 x 6.
        md_lat = 2;
        set_req(0, OP_MULT, 32'd7, 32'd6);
        wait_grant(0);
        take_rsp(0, 0);

        // Simultaneous requests after reset: req0 first, then req0 re-arms
        // while req1 still waits, so req1 must win the next tie.
        do_reset();
        set_req(0, OP_DIV, 32'd100, 32'd7);
        set_req(1, OP_MULT, 32'd3, 32'd5);
        wait_grant(0);
        take_rsp(0, 0);
        set_req(0, OP_MULT, 32'd9, 32'd9);
        wait_grant(1);
        take_rsp(1, 0);
        wait_grant(0);
        take_rsp(0, 0);

        // Divide by zero exception passthrough.
        set_req(0, OP_DIV, 32'd5, 32'd0);
        wait_grant(0);
        take_rsp(0, 0);

        // Timeout: model never answers.
        md_never = 1'b1;
        set_req(1, OP_MULT, 32'd11, 32'd13);
        wait_grant(1);
        take_rsp(1, 0);
        md_never = 1'b0;

        // Back-pressured response; competing request must wait one idle cycle.
        md_lat = 1;
        set_req(0, OP_MULT, 32'd123, 32'd456);
        wait_grant(0);
        set_req(1, OP_DIV, 32'd1000, 32'd10);
        take_rsp(0, 10);
        check("no_bypass_next", 32'(req_ready), 32'd2);
        wait_grant(1);
        take_rsp(1, 0);

        // Reset during WAIT: the late result must not produce a response.
        md_lat = 6;
        set_req(0, OP_MULT, 32'd2, 32'd3);
        wait_grant(0);
        tick();
        tick();
        tick();
        void'(exp_q.pop_front());
        reset = 1'b1;
        tick();
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_rsp", 32'(rsp_valid), 32'd0);
        end
        md_lat = 2;
        set_req(1, OP_MULT, 32'd20, 32'd30);
        wait_grant(1);
        take_rsp(1, 0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
